register_n: RTL and testbench
=============================

// Module: register_n
// PURPOSE
//  - Generic N-bit storage register with write enable and asynchronous reset.
//  - Basic state element for datapath pipeline registers, the PC, and CSR/GPR holding cells.
//  - Loads i_D on a rising clock edge when enabled; otherwise holds its value.
// PARAMETERS
//  - N            default 32   data width in bits; legal range N >= 1
//  - RESET_VALUE  default '0   N-bit value loaded into o_Q while i_Reset is high
// PORTS
//  - i_Clock        input   1   single clock; all state updates on rising edge
//  - i_Reset        input   1   asynchronous, active-high reset
//  - i_WriteEnable  input   1   1 = capture i_D on next rising edge; 0 = hold
//  - i_D            input   N   data to store
//  - o_Q            output  N   stored value, driven directly from flops
//  - o_Parity       output  1   only with REGISTER_N_PARITY_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset:
//    - i_Reset=1 forces o_Q=RESET_VALUE immediately, with no clock edge needed.
//    - o_Q stays at RESET_VALUE while i_Reset is high.
//    - Reset is asynchronous and active-high: one clock, async assert, sensitivity on posedge i_Clock or posedge i_Reset.
//  - Reset priority:
//    - Reset dominates i_WriteEnable.
//    - A clock edge while i_Reset=1 does not load i_D.
//  - Reset release:
//    - After i_Reset falls, the first rising edge with i_WriteEnable=1 loads i_D.
//    - Rising edges with i_WriteEnable=0 keep RESET_VALUE.
//  - Write:
//    - On a rising i_Clock edge with i_Reset=0 and i_WriteEnable=1: o_Q <= i_D (all N bits).
//    - Latency is one edge: the new value is visible on o_Q after the edge (clock-to-q), never combinationally.
//  - Hold:
//    - i_WriteEnable=0 on an edge keeps o_Q unchanged, whatever i_D is.
//    - No partial or byte writes.
//  - Back-to-back writes:
//    - Each enabled edge captures the i_D present at that edge.
//    - Consecutive enabled edges update o_Q every cycle.
//  - Timing and sampling:
//    - o_Q depends only on stored state.
//    - No combinational path from i_D or i_WriteEnable to o_Q.
//    - Inputs are sampled only at the rising edge; glitches between edges have no effect.
//  - Reset mid-operation:
//    - Asserting i_Reset between edges clears o_Q at once.
//    - A pending enabled write is lost.
//  - Width rules:
//    - i_D and o_Q are exactly N bits, with no sign or zero extension inside the block.
//    - RESET_VALUE is truncated or extended to N bits at elaboration.
// CONFIGURATION
//  - Macro REGISTER_N_PARITY_EN.
//  - Defined:
//    - Adds output o_Parity, a registered even-parity bit (^data) stored alongside the data.
//    - It updates on the same enabled edge as o_Q.
//    - On reset it takes ^RESET_VALUE.
//    - It holds when i_WriteEnable=0.
//  - Not defined:
//    - The o_Parity port and its flop do not exist.
//    - Port list is exactly clock, reset, write enable, D, Q.
//  - o_Q behaviour is identical in both builds.
// TESTING (N=32, RESET_VALUE=0; inputs change mid-cycle, checks 1 ns after rising edge)
//  - Pulse i_Reset for 2 half-cycles, then WE=0, D=0000_FFFF for one edge -> o_Q=0000_0000
//  - WE=1, D=0000_FFFF -> o_Q=0000_FFFF; then WE=0, D=0000_0000 and WE=0, D=AAAA_0000 -> o_Q stays 0000_FFFF
//  - WE=1, D=AAAA_0000 then WE=1, D=FEED_FACE on consecutive edges -> o_Q=AAAA_0000 then FEED_FACE
//  - WE=0, D=DEAD_BEEF -> o_Q remains FEED_FACE
//  - Assert i_Reset mid-cycle with WE=1, D=1234_5678 -> o_Q=0000_0000 before the next edge, still 0 after that edge
//  - REGISTER_N_PARITY_EN build: load 0000_0001 -> o_Parity=1; load 0000_0003 -> o_Parity=0; reset -> o_Parity=0

Source files
------------

// File: rtl/register_n.sv
// -----------------------------------------------------------------------------
// register_n
//
// Purpose:
//   Generic N-bit storage register with a write enable and an asynchronous,
//   active-high reset. This is the basic state element for pipeline registers,
//   the PC, and CSR/GPR holding cells. i_D is loaded on a rising clock edge
//   when i_WriteEnable is high. Otherwise the stored value is held.
//
// Parameters:
//   N            data width in bits (N >= 1), default 32
//   RESET_VALUE  value forced onto o_Q while i_Reset is high. Because it is
//                typed as N bits, it is truncated or extended at elaboration.
//
// Ports:
//   i_Clock        in   1  rising-edge clock
//   i_Reset        in   1  asynchronous, active-high reset (dominates write)
//   i_WriteEnable  in   1  1 = capture i_D on the next rising edge, 0 = hold
//   i_D            in   N  data to store
//   o_Q            out  N  stored value, driven directly from flops
//   o_Parity       out  1  registered even parity (^data) of the stored word.
//                          Present only when REGISTER_N_PARITY_EN is defined.
//
// Configuration:
//   `define REGISTER_N_PARITY_EN  adds the o_Parity port and its flop.
//   When the macro is undefined, the port list is exactly
//   clock, reset, write enable, D, Q.
// -----------------------------------------------------------------------------
module register_n #(
  parameter int           N           = 32,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic         i_Clock,
  input  logic         i_Reset,
  input  logic         i_WriteEnable,
  input  logic [N-1:0] i_D,
  output logic [N-1:0] o_Q
`ifdef REGISTER_N_PARITY_EN
  ,
  output logic         o_Parity
`endif
);

  // Reset has priority over the write enable. A clock edge that arrives while
  // i_Reset is high never loads i_D. When the enable is low, the missing else
  // branch is the intended hold: it is a flop, not a latch.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // flop samples the pre-edge values, whatever the evaluation order.
      o_Q <= RESET_VALUE;
    end else if (i_WriteEnable) begin
      o_Q <= i_D;
    end
  end

`ifdef REGISTER_N_PARITY_EN
  // The parity bit is stored alongside the data rather than derived from o_Q.
  // This keeps it a true flop output, updated on exactly the same edges as
  // o_Q, so a later consumer can compare the two to detect upsets.
  localparam logic RESET_PARITY = ^RESET_VALUE;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Parity <= RESET_PARITY;
    end else if (i_WriteEnable) begin
      o_Parity <= ^i_D;
    end
  end
`endif

endmodule

// File: tb/tb_register_n.sv
// -----------------------------------------------------------------------------
// tb_register_n
//
// Self-checking bench for register_n (N=32, RESET_VALUE=0).
// Inputs change on the falling edge, and outputs are checked 1 ns after each
// rising edge.
//
// The expected value of o_Q is kept as a transaction-level model: "the last
// word accepted by an enabled, non-reset edge since the most recent reset".
// Each stimulus task records what the register must hold after its edge. A
// single compare process checks the DUT against that record on every edge.
// Literal spot checks pin the model to hand-computed values.
//
// Define REGISTER_N_PARITY_EN to also check o_Parity.
// -----------------------------------------------------------------------------
module tb_register_n;

  localparam int          N   = 32;
  localparam logic [31:0] RST = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we  = 1'b0;
  logic [N-1:0]  d   = '0;
  logic [N-1:0]  q;
`ifdef REGISTER_N_PARITY_EN
  logic          par;
`endif

  int total = 0;
  int bad   = 0;

  // Model state: value the register must hold after the current edge.
  logic [N-1:0] model_q = RST;
  // One entry per rising edge that the stimulus has fully specified.
  logic [N-1:0] exp_q[$];
  logic [N-1:0] mon_exp;

  always #5 clk = ~clk;

  register_n #(
    .N           (N),
    .RESET_VALUE (RST)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_WriteEnable (we),
    .i_D           (d),
    .o_Q           (q)
`ifdef REGISTER_N_PARITY_EN
    ,
    .o_Parity      (par)
`endif
  );

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every rising edge with a recorded expectation is checked.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check("cycle_q", q, mon_exp);
`ifdef REGISTER_N_PARITY_EN
      check1("cycle_parity", par, ^mon_exp);
`endif
    end
  end

  // Each task is entered at a falling edge and returns at the next falling edge.
  // An edge loads D only when reset is low and the enable is high.
  task automatic step(input logic w, input logic [N-1:0] data);
    we = w;
    d  = data;
    if (!rst && w) model_q = data;
    exp_q.push_back(model_q);
    @(negedge clk);
  endtask

  // Enable pulses high with junk data between edges, then settles low before
  // the edge. Nothing may be captured.
  task automatic glitch(input logic [N-1:0] junk, input logic [N-1:0] settle);
    we = 1'b1;
    d  = junk;
    #2;
    we = 1'b0;
    d  = settle;
    exp_q.push_back(model_q);
    @(negedge clk);
  endtask

  // Reset raised mid-cycle: o_Q must clear at once, without a clock edge.
  // Reset is held through the following rising edge, so any write set up
  // with it is lost. Reset is released at the next falling edge.
  task automatic reset_pulse(input logic w, input logic [N-1:0] data);
    we  = w;
    d   = data;
    rst = 1'b1;
    model_q = RST;
    #1;
    check("reset_async", q, RST);
    exp_q.push_back(model_q);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);

    // Reset pulse of two half-cycles, then a disabled edge keeps the reset value.
    reset_pulse(1'b0, 32'h0000_0000);
    step(1'b0, 32'h0000_FFFF);
    check("after_reset_hold", q, 32'h0000_0000);

    // Basic load, then hold against changing D.
    step(1'b1, 32'h0000_FFFF);
    check("load_ffff", q, 32'h0000_FFFF);
    step(1'b0, 32'h0000_0000);
    step(1'b0, 32'hAAAA_0000);
    check("hold_ffff", q, 32'h0000_FFFF);

    // Back-to-back writes.
    step(1'b1, 32'hAAAA_0000);
    check("b2b_first", q, 32'hAAAA_0000);
    step(1'b1, 32'hFEED_FACE);
    check("b2b_second", q, 32'hFEED_FACE);
    step(1'b0, 32'hDEAD_BEEF);
    check("hold_feedface", q, 32'hFEED_FACE);

    // Glitch on the enable between edges must not load.
    glitch(32'h0BAD_0BAD, 32'h1111_2222);
    check("glitch_ignored", q, 32'hFEED_FACE);

    // Mid-cycle reset with a pending enabled write. The write is lost.
    reset_pulse(1'b1, 32'h1234_5678);
    check("reset_kills_write", q, 32'h0000_0000);

    // After release, a disabled edge keeps the reset value and the first
    // enabled edge loads.
    step(1'b0, 32'h5555_AAAA);
    check("release_hold", q, 32'h0000_0000);
    step(1'b1, 32'h5555_AAAA);
    check("release_load", q, 32'h5555_AAAA);

    // Boundary patterns: all ones, all zeros, single MSB.
    step(1'b1, 32'hFFFF_FFFF);
    check("all_ones", q, 32'hFFFF_FFFF);
    step(1'b1, 32'h0000_0000);
    check("all_zeros", q, 32'h0000_0000);
    step(1'b1, 32'h8000_0000);
    check("msb_only", q, 32'h8000_0000);

    // Parity patterns: o_Q is checked in both builds, and o_Parity is
    // checked when the parity build is enabled.
    step(1'b1, 32'h0000_0001);
    check("load_one", q, 32'h0000_0001);
`ifdef REGISTER_N_PARITY_EN
    check1("parity_one", par, 1'b1);
`endif
    step(1'b1, 32'h0000_0003);
    check("load_three", q, 32'h0000_0003);
`ifdef REGISTER_N_PARITY_EN
    check1("parity_three", par, 1'b0);
`endif
    step(1'b1, 32'h0000_0007);
    step(1'b0, 32'h0000_0001);
    check("hold_seven", q, 32'h0000_0007);
`ifdef REGISTER_N_PARITY_EN
    check1("parity_hold", par, 1'b1);
`endif
    reset_pulse(1'b0, 32'h0000_0000);
    check("final_reset", q, 32'h0000_0000);
`ifdef REGISTER_N_PARITY_EN
    check1("parity_reset", par, 1'b0);
`endif

    // Let the compare process drain any remaining expectation.
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
